// File: rtl/enc_pkg.sv
// Shared definitions for the event encoder: size limit, index-width helper
// and a one-hot decoder used to turn an index back into a bit mask.
package enc_pkg;

  localparam int MAX_N = 64;

  // Index width for an N-entry vector; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // One-hot mask of idx within an n-wide field; all zeros if idx is out of range.
  function automatic logic [MAX_N-1:0] onehot(input int idx, input int n);
    logic [MAX_N-1:0] v;
    for (int i = 0; i < MAX_N; i++) begin
      v[i] = (i == idx) && (i < n);
    end
    return v;
  endfunction

endpackage

// File: rtl/prio_rr_select.sv
// Combinational selector: lowest set candidate, or the first set candidate at
// or after ptr with wrap-around. The candidate vector is laid out twice so the
// wrap becomes a plain lowest-bit search over a masked double-width vector.
module prio_rr_select
  import enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = idx_width(N)
) (
  input  logic [N-1:0] cand,
  input  logic [W-1:0] ptr,
  input  logic         rr_mode,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;

  // Duplicate the candidates and drop positions below the search start.
  always_comb begin
    dbl = {cand, cand};
    for (int i = 0; i < 2*N; i++) begin
      masked[i] = dbl[i] && (!rr_mode || (i >= int'(ptr)));
    end
  end

  // Lowest surviving position wins; upper-half hits fold back modulo N.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (masked[i]) begin
        found = 1'b1;
        idx   = (i >= N) ? W'(i - N) : W'(i);
      end
    end
  end

endmodule

// File: rtl/prio_event_encoder.sv
// Registered event-to-index encoder. Event pulses are held in sticky pending
// bits and handed out one index at a time on a valid/ready port, by fixed
// priority or round-robin, so simultaneous events are never lost.
module prio_event_encoder
  import enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = idx_width(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [N-1:0] d,
  input  logic         rr_mode,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] y,
  output logic [N-1:0] pending,
  output logic         overflow
);

  logic [N-1:0] y_oh;
  logic [N-1:0] clr;
  logic [N-1:0] d_en;
  logic [N-1:0] pending_next;
  logic [N-1:0] cand;
  logic         accept;
  logic         load;
  logic         ovf_next;
  logic         found;
  logic [W-1:0] sel_idx;
  logic [W-1:0] ptr;
  logic [W-1:0] ptr_next;

  // Transfer handshake, pending update and the candidate set for the next load.
  // The in-flight index is masked out of the candidates so it is never reselected,
  // and a new event on the bit being cleared re-pends it (set wins over clear).
  always_comb begin
    y_oh         = N'(onehot(int'(y), N));
    accept       = out_valid & out_ready;
    load         = ~out_valid | accept;
    clr          = accept ? y_oh : '0;
    d_en         = enable ? d : '0;
    pending_next = (pending & ~clr) | d_en;
    ovf_next     = |(d_en & pending & ~clr);
    cand         = pending & ~(out_valid ? y_oh : '0);
    ptr_next     = (y == W'(N - 1)) ? '0 : (y + 1'b1);
  end

  prio_rr_select #(.N(N)) u_select (
    .cand    (cand),
    .ptr     (ptr),
    .rr_mode (rr_mode),
    .idx     (sel_idx),
    .found   (found)
  );

  // State update; reset clears everything, including a transfer in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending   <= '0;
      out_valid <= 1'b0;
      y         <= '0;
      overflow  <= 1'b0;
      ptr       <= '0;
    end else begin
      pending  <= pending_next;
      overflow <= ovf_next;
      if (load) begin
        out_valid <= found;
        if (found) begin
          y <= sel_idx;
        end
      end
      if (accept && rr_mode) begin
        ptr <= ptr_next;
      end
    end
  end

endmodule

// File: tb/tb_prio_event_encoder.sv
// Bench for prio_event_encoder (N=8): directed scenarios followed by random
// traffic, checked against a cycle-level behavioural model. Expected indices
// are queued at issue time and consumed by an independent monitor.
module tb_prio_event_encoder;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic [N-1:0] d;
  logic         rr_mode;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] y;
  logic [N-1:0] pending;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  int expq[$];
  int got[$];

  // reference model state
  bit           m_known = 1'b0;
  bit [N-1:0]   mp;
  bit           mv;
  int           my;
  int           mptr;
  bit           movf;

  // snapshot of what the DUT should currently present
  bit           cur_known = 1'b0;
  bit [N-1:0]   cur_pend;
  bit           cur_v;
  bit           cur_ovf;

  always #5 clk = ~clk;

  prio_event_encoder #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .d         (d),
    .rr_mode   (rr_mode),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .y         (y),
    .pending   (pending),
    .overflow  (overflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive inputs, then advance the model to the next edge.
  task automatic step(input bit rst, input bit en, input logic [N-1:0] dv,
                      input bit rr, input bit rdy);
    bit         acc;
    bit         ev;
    bit         cleared;
    bit [N-1:0] np;
    bit         novf;
    bit         nv;
    int         ny;
    int         nptr;
    int         start;
    int         idx;
    @(negedge clk);
    rst_n     = rst;
    enable    = en;
    d         = dv;
    rr_mode   = rr;
    out_ready = rdy;
    cur_known = m_known;
    cur_pend  = mp;
    cur_v     = mv;
    cur_ovf   = movf;
    if (!rst) begin
      mp = '0; mv = 1'b0; my = 0; mptr = 0; movf = 1'b0;
      m_known = 1'b1;
    end else if (m_known) begin
      acc = mv && rdy;
      if (acc) expq.push_back(my);
      novf = 1'b0;
      for (int i = 0; i < N; i++) begin
        cleared = acc && (i == my);
        ev      = en && dv[i];
        if (ev && mp[i] && !cleared) novf = 1'b1;
        np[i] = (mp[i] && !cleared) || ev;
      end
      nv = mv; ny = my; nptr = mptr;
      if (!mv || acc) begin
        start = rr ? mptr : 0;
        nv = 1'b0;
        for (int k = 0; k < N; k++) begin
          idx = (start + k) % N;
          if (mp[idx] && !(mv && idx == my)) begin
            nv = 1'b1;
            ny = idx;
            break;
          end
        end
      end
      if (acc && rr) nptr = (my + 1) % N;
      mp = np; mv = nv; my = ny; mptr = nptr; movf = novf;
    end
  endtask

  task automatic seq_chk(input string name, input int e[6], input int n, input bit exact);
    if (exact) chk({name, "_count"}, 64'(got.size()), 64'(n));
    else       chk({name, "_count_min"}, 64'(got.size() >= n), 64'd1);
    for (int i = 0; i < n && i < got.size(); i++) chk(name, 64'(got[i]), 64'(e[i]));
  endtask

  // Monitor: compares visible state each cycle and pops one expectation per transfer.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (cur_known) begin
        chk("pending", 64'(pending), 64'(cur_pend));
        chk("overflow", 64'(overflow), 64'(cur_ovf));
        chk("out_valid", 64'(out_valid), 64'(cur_v));
        if (rst_n && out_valid && out_ready) begin
          got.push_back(int'(y));
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL y_unexpected actual=%0d required=none at %0t", y, $time);
          end else begin
            chk("y", 64'(y), 64'(expq.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; d = '0; rr_mode = 1'b0; out_ready = 1'b0;

    // reset, then a single event
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    got.delete();
    step(1, 1, 8'h04, 0, 1);
    repeat (4) step(1, 1, 8'h00, 0, 1);
    #2 chk("t1_pending_clear", 64'(pending), 64'h0);
    seq_chk("t1_seq", '{2, 0, 0, 0, 0, 0}, 1, 1'b1);

    // fixed priority, multi-hot burst
    got.delete();
    step(1, 1, 8'h92, 0, 1);
    repeat (5) step(1, 1, 8'h00, 0, 1);
    #2 chk("t2_idle", 64'(out_valid), 64'h0);
    seq_chk("t2_seq", '{1, 4, 7, 0, 0, 0}, 3, 1'b1);

    // round-robin with 0,3,5 re-asserted every cycle
    got.delete();
    repeat (9) step(1, 1, 8'h29, 1, 1);
    repeat (6) step(1, 1, 8'h00, 1, 1);
    seq_chk("t3_rr_seq", '{0, 3, 5, 0, 3, 5}, 6, 1'b0);

    // same stimulus in fixed mode
    got.delete();
    repeat (7) step(1, 1, 8'h29, 0, 1);
    repeat (6) step(1, 1, 8'h00, 0, 1);
    seq_chk("t3_fixed_seq", '{0, 3, 0, 3, 0, 0}, 4, 1'b0);

    // backpressure holds y
    got.delete();
    step(1, 1, 8'h40, 0, 0);
    step(1, 1, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, (i == 0) ? 8'h01 : 8'h00, 0, 0);
      #2 chk("t4_hold_y", 64'(y), 64'd6);
    end
    repeat (4) step(1, 1, 8'h00, 0, 1);
    seq_chk("t4_seq", '{6, 0, 0, 0, 0, 0}, 2, 1'b1);

    // overflow and set-wins-over-clear
    got.delete();
    step(1, 1, 8'h08, 0, 0);
    step(1, 1, 8'h08, 0, 0);
    step(1, 1, 8'h08, 0, 1);
    #2 chk("t5_overflow", 64'(overflow), 64'd1);
    step(1, 1, 8'h00, 0, 1);
    #2 chk("t5_no_overflow", 64'(overflow), 64'd0);
    chk("t5_repend", 64'(pending), 64'h08);
    repeat (3) step(1, 1, 8'h00, 0, 1);
    seq_chk("t5_seq", '{3, 3, 0, 0, 0, 0}, 2, 1'b1);

    // reset mid-stream, then enable=0 ignores events
    step(1, 1, 8'hFF, 0, 0);
    step(1, 1, 8'h00, 0, 0);
    #2 chk("t6_pre_pending", 64'(pending), 64'hFF);
    step(0, 1, 8'hFF, 0, 1);
    step(1, 0, 8'hFF, 0, 1);
    #2 chk("t6_rst_pending", 64'(pending), 64'h0);
    chk("t6_rst_valid", 64'(out_valid), 64'h0);
    chk("t6_rst_y", 64'(y), 64'h0);
    step(1, 0, 8'hFF, 0, 1);
    #2 chk("t6_disabled_pending", 64'(pending), 64'h0);
    chk("t6_disabled_overflow", 64'(overflow), 64'h0);

    // random traffic
    begin
      bit rr = 1'b0;
      for (int c = 0; c < 600; c++) begin
        if ($urandom_range(0, 19) == 0) rr = ~rr;
        step(($urandom_range(0, 79) != 0),
             ($urandom_range(0, 3) != 0),
             N'($urandom & $urandom & $urandom),
             rr,
             ($urandom_range(0, 2) != 0));
      end
    end
    repeat (20) step(1, 0, 8'h00, 0, 1);
    @(negedge clk);
    #2 chk("queue_drained", 64'(expq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
